// File: rtl/modalu_if.sv
// Operation/result bus between the inversion sequencer (master) and modalu (slave).
interface modalu_if #(
  parameter int WID = 256
);
  logic           aen;
  logic [1:0]     aop;
  logic [WID-1:0] ara;
  logic [WID-1:0] arb;
  logic [WID-1:0] adi;
  logic           adivld;
  logic           abusy;

  modport master (output aen, aop, ara, arb, input adi, adivld, abusy);
  modport slave  (input aen, aop, ara, arb, output adi, adivld, abusy);
endinterface

// File: rtl/modalu.sv
// Modular ADD/SUB/MUL/INV modulo prime P with bit-serial MSB-first multiplier.
// Optional feature macro: MODALU_INV_EN compiles in the Fermat inversion path.
module modalu #(
  parameter int             WID = 256,
  parameter logic [WID-1:0] P   = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF
) (
  input  logic     clk,
  input  logic     rst,
  modalu_if.slave  bus
);

  localparam int             CW      = $clog2(WID);
  localparam logic [WID:0]   PX      = {1'b0, P};
  localparam logic [CW-1:0]  CNT_TOP = CW'(WID - 1);
  localparam logic [CW-1:0]  CNT_0   = {CW{1'b0}};
`ifdef MODALU_INV_EN
  localparam logic [WID-1:0] E       = P - WID'(2'd2);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADD    = 3'd1,
    S_RED    = 3'd2,
    S_MUL    = 3'd3,
    S_INV_SQ = 3'd4,
    S_INV_MU = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  function automatic logic [WID-1:0] sub_p(input logic [WID:0] v);
    logic [WID:0] t;
    t = (v >= PX) ? (v - PX) : v;
    return t[WID-1:0];
  endfunction

  state_t         r_state;
  state_t         w_state_nxt;
  logic [WID-1:0] r_opa;
  logic [WID-1:0] r_opb;
  logic [1:0]     r_opc;
  logic [WID-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_ld;
  logic [WID-1:0] r_adi;
  logic           r_adivld;
  logic           r_abusy;
`ifdef MODALU_INV_EN
  logic [WID-1:0] r_r;
  logic [WID-1:0] r_base;
  logic [CW-1:0]  r_idx;
  logic           w_ebit;
  logic           w_bit_done;
`endif

  logic [WID-1:0] w_ea;
  logic [WID-1:0] w_eb;
  logic [WID-1:0] w_dbl;
  logic [WID-1:0] w_step;
  logic [WID-1:0] w_addres;
  logic [WID-1:0] w_res_nxt;
  logic           w_vld_nxt;
  logic           w_last;

  assign bus.adi    = r_adi;
  assign bus.adivld = r_adivld;
  assign bus.abusy  = r_abusy;

  // Multiplier operand select: plain MUL uses captured operands, INV uses r and base.
  always_comb begin
    w_ea = r_opa;
    w_eb = r_opb;
`ifdef MODALU_INV_EN
    if (r_state == S_INV_SQ) begin
      w_ea = r_r;
      w_eb = r_r;
    end else if (r_state == S_INV_MU) begin
      w_ea = r_base;
      w_eb = r_r;
    end else begin
      w_ea = r_opa;
      w_eb = r_opb;
    end
`endif
  end

  // One shift-add step and the single-cycle add/sub result.
  always_comb begin
    w_dbl  = sub_p({r_acc, 1'b0});
    w_step = w_eb[r_cnt] ? sub_p({1'b0, w_dbl} + {1'b0, w_ea}) : w_dbl;
    w_last = (r_ld == 2'd0) && (r_cnt == CNT_0);
    case (r_opc)
      2'b00:   w_addres = sub_p({1'b0, r_opa} + {1'b0, r_opb});
      2'b01:   w_addres = sub_p((r_opa < r_opb) ? ({1'b0, r_opa} + PX - {1'b0, r_opb})
                                                : ({1'b0, r_opa} - {1'b0, r_opb}));
      default: w_addres = {WID{1'b0}};
    endcase
  end

`ifdef MODALU_INV_EN
  assign w_ebit     = E[r_idx];
  assign w_bit_done = (r_state == S_INV_MU) || !w_ebit;
`endif

  // Next-state logic; result and valid are looked ahead so the outputs stay registered.
  always_comb begin
    w_state_nxt = r_state;
    w_vld_nxt   = 1'b0;
    w_res_nxt   = r_adi;
    case (r_state)
      S_IDLE: begin
        if (bus.aen) begin
          case (bus.aop)
            2'b10:   w_state_nxt = S_MUL;
`ifdef MODALU_INV_EN
            2'b11:   w_state_nxt = S_INV_SQ;
`endif
            default: w_state_nxt = S_ADD;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADD: begin
        w_state_nxt = S_RED;
        w_vld_nxt   = 1'b1;
        w_res_nxt   = w_addres;
      end
      S_RED:  w_state_nxt = S_IDLE;
      S_MUL: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_vld_nxt   = 1'b1;
          w_res_nxt   = w_step;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
`ifdef MODALU_INV_EN
      S_INV_SQ, S_INV_MU: begin
        if (!w_last) begin
          w_state_nxt = r_state;
        end else if (r_state == S_INV_SQ && w_ebit) begin
          w_state_nxt = S_INV_MU;
        end else if (r_idx == CNT_0) begin
          w_state_nxt = S_DONE;
          w_vld_nxt   = 1'b1;
          w_res_nxt   = w_step;
        end else begin
          w_state_nxt = S_INV_SQ;
        end
      end
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, multiplier engine and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_opa    <= {WID{1'b0}};
      r_opb    <= {WID{1'b0}};
      r_opc    <= 2'b00;
      r_acc    <= {WID{1'b0}};
      r_cnt    <= CNT_0;
      r_ld     <= 2'd0;
      r_adi    <= {WID{1'b0}};
      r_adivld <= 1'b0;
      r_abusy  <= 1'b0;
`ifdef MODALU_INV_EN
      r_r      <= {WID{1'b0}};
      r_base   <= {WID{1'b0}};
      r_idx    <= CNT_0;
`endif
    end else begin
      r_adi    <= w_res_nxt;
      r_adivld <= w_vld_nxt;
      r_abusy  <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (bus.aen) begin
            r_opa <= bus.ara;
            r_opb <= bus.arb;
            r_opc <= bus.aop;
            r_ld  <= 2'd1;
`ifdef MODALU_INV_EN
            r_idx <= CNT_TOP;
            r_r   <= {{(WID-1){1'b0}}, 1'b1};
            // Inversion spends one extra cycle moving the operand into base.
            if (bus.aop == 2'b11) begin
              r_ld <= 2'd2;
            end else begin
              r_ld <= 2'd1;
            end
`endif
          end else begin
            r_ld <= r_ld;
          end
        end
        S_MUL, S_INV_SQ, S_INV_MU: begin
          if (r_ld != 2'd0) begin
            r_ld  <= r_ld - 2'd1;
            r_acc <= {WID{1'b0}};
            r_cnt <= CNT_TOP;
`ifdef MODALU_INV_EN
            r_base <= r_opa;
`endif
          end else begin
            r_acc <= w_step;
            if (r_cnt != CNT_0) begin
              r_cnt <= r_cnt - CW'(1'b1);
            end else begin
              r_ld <= 2'd1;
`ifdef MODALU_INV_EN
              r_r <= w_step;
              if (r_state != S_MUL && w_bit_done && r_idx != CNT_0) begin
                r_idx <= r_idx - CW'(1'b1);
              end else begin
                r_idx <= r_idx;
              end
`endif
            end
          end
        end
        default: begin
          r_ld <= r_ld;
        end
      endcase
    end
  end

endmodule
